// File: rtl/ws2811_rx_if.sv
// Line-side bundle of the WS2811 receiver: the one-wire input plus the decoded pixel,
// latch, forwarded-stream and error outputs.
interface ws2811_rx_if;
    logic        din;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        latch;
    logic        dout;
    logic        bit_error;

    modport master (
        output din,
        input  pixel_data, pixel_valid, latch, dout, bit_error
    );

    modport slave (
        input  din,
        output pixel_data, pixel_valid, latch, dout, bit_error
    );
endinterface

// File: rtl/ws2811_rx.sv
// WS2811 one-wire receiver acting as the first LED of a chain: captures the first
// 24 bits of a frame, forwards the rest on dout and reports the latch gap.
module ws2811_rx #(
    parameter int unsigned T_MIN_HIGH   = 8,
    parameter int unsigned T_THRESH     = 42,
    parameter int unsigned T_MAX_HIGH   = 100,
    parameter int unsigned RESET_CYCLES = 2500
) (
    input  logic        clk,
    input  logic        rst,
    ws2811_rx_if.slave  bus
);

    typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

    localparam logic [7:0]  MIN_H = 8'(T_MIN_HIGH);
    localparam logic [7:0]  THR_H = 8'(T_THRESH);
    localparam logic [7:0]  MAX_H = 8'(T_MAX_HIGH);
    localparam logic [11:0] GAP   = 12'(RESET_CYCLES);

    state_t      state;
    logic        din_meta;
    logic        ds;
    logic [7:0]  high_cnt;
    logic [11:0] low_cnt;
    logic [4:0]  bit_cnt;
    logic [23:0] shift_reg;
    logic        fwd;
    logic        captured;

    logic [23:0] pixel_data_r;
    logic        pixel_valid_r;
    logic        latch_r;
    logic        dout_r;
    logic        bit_error_r;

    logic [7:0]  high_inc;
    logic [11:0] low_inc;
    logic        gap_hit;
    logic        bit_val;
    logic [23:0] shift_next;

    // Both counters stop at their limit; low_cnt parks at GAP so a gap fires only once.
    assign high_inc   = (high_cnt == 8'hFF) ? high_cnt : high_cnt + 8'd1;
    assign low_inc    = (low_cnt >= GAP) ? low_cnt : low_cnt + 12'd1;
    assign gap_hit    = !ds && (low_cnt == GAP - 12'd1);
    assign bit_val    = (high_cnt >= THR_H);
    assign shift_next = {shift_reg[22:0], bit_val};

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SYNC;
            din_meta      <= 1'b0;
            ds            <= 1'b0;
            high_cnt      <= '0;
            low_cnt       <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            fwd           <= 1'b0;
            captured      <= 1'b0;
            pixel_data_r  <= '0;
            pixel_valid_r <= 1'b0;
            latch_r       <= 1'b0;
            dout_r        <= 1'b0;
            bit_error_r   <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere so every branch below sees pre-edge values.
            din_meta      <= bus.din;
            ds            <= din_meta;
            pixel_valid_r <= 1'b0;
            latch_r       <= 1'b0;
            bit_error_r   <= 1'b0;
            dout_r        <= fwd & ds;

            case (state)
                SYNC: begin
                    if (ds) begin
                        low_cnt <= '0;
                    end else begin
                        low_cnt <= low_inc;
                        if (gap_hit) begin
                            state   <= LOW;
                            bit_cnt <= '0;
                        end
                    end
                end

                LOW: begin
                    if (ds) begin
                        high_cnt <= 8'd1;
                        low_cnt  <= '0;
                        state    <= HIGH;
                    end else begin
                        low_cnt <= low_inc;
                        if (gap_hit) begin
                            latch_r  <= captured;
                            captured <= 1'b0;
                            fwd      <= 1'b0;
                            bit_cnt  <= '0;
                        end
                    end
                end

                HIGH: begin
                    if (ds) begin
                        high_cnt <= high_inc;
                        if (high_inc == MAX_H) begin
                            bit_error_r <= 1'b1;
                            state       <= SYNC;
                            fwd         <= 1'b0;
                            bit_cnt     <= '0;
                            low_cnt     <= '0;
                        end
                    end else if (high_cnt < MIN_H) begin
                        bit_error_r <= 1'b1;
                        state       <= SYNC;
                        fwd         <= 1'b0;
                        bit_cnt     <= '0;
                        low_cnt     <= 12'd1;
                    end else begin
                        // The falling-edge cycle is the first low cycle of a possible gap.
                        state   <= LOW;
                        low_cnt <= 12'd1;
                        if (!fwd) begin
                            if (bit_cnt == 5'd23) begin
                                pixel_data_r  <= shift_next;
                                pixel_valid_r <= 1'b1;
                                fwd           <= 1'b1;
                                captured      <= 1'b1;
                                bit_cnt       <= '0;
                            end else begin
                                shift_reg <= shift_next;
                                bit_cnt   <= bit_cnt + 5'd1;
                            end
                        end
                    end
                end

                default: state <= SYNC;
            endcase
        end
    end

    assign bus.pixel_data  = pixel_data_r;
    assign bus.pixel_valid = pixel_valid_r;
    assign bus.latch       = latch_r;
    assign bus.dout        = dout_r;
    assign bus.bit_error   = bit_error_r;

endmodule

// File: tb/tb_ws2811_rx.sv
// Directed bench for ws2811_rx: threshold table plus hand-written frame, chain,
// error-recovery, partial-frame and mid-frame-reset sequences.
module tb_ws2811_rx;

    localparam int GAP = 2550;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    ws2811_rx_if bus ();
    ws2811_rx dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Cycle counter and output monitor, sampled on the falling edge.
    int   cyc = 0;
    int   n_valid = 0, n_latch = 0, n_err = 0, n_dout_hi = 0, n_both = 0;
    int   latch_cyc = 0;
    int   run = 0;
    logic dout_q = 1'b0;
    int   dout_rise[$];
    int   dout_width[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.pixel_valid === 1'b1) n_valid <= n_valid + 1;
        if (bus.bit_error === 1'b1)   n_err   <= n_err + 1;
        if (bus.latch === 1'b1) begin
            n_latch   <= n_latch + 1;
            latch_cyc <= cyc;
        end
        if (bus.pixel_valid === 1'b1 && bus.latch === 1'b1) n_both <= n_both + 1;
        if (bus.dout === 1'b1) begin
            n_dout_hi <= n_dout_hi + 1;
            if (!dout_q) begin
                dout_rise.push_back(cyc);
                run <= 1;
            end else begin
                run <= run + 1;
            end
        end else if (dout_q) begin
            dout_width.push_back(run);
            run <= 0;
        end
        dout_q <= (bus.dout === 1'b1);
    end

    int din_rise[$];
    int last_fall = 0;
    int v0, l0, e0, h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input int w, input int period);
        bus.din = 1'b1;
        din_rise.push_back(cyc);
        tick(w);
        bus.din = 1'b0;
        last_fall = cyc;
        tick(period - w);
    endtask

    task automatic send_word(input logic [23:0] v, input int period, input int nbits);
        for (int i = 0; i < nbits; i++)
            send_bit(v[23 - i] ? 60 : 24, period);
    endtask

    task automatic snap();
        v0 = n_valid;
        l0 = n_latch;
        e0 = n_err;
        h0 = n_dout_hi;
    endtask

    typedef struct {
        string       name;
        logic [22:0] pfx;
        int          w;
        logic        exp_err;
        logic        exp_bit;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int rb, wb, db, nbad_w, nbad_d;

        vecs[0] = '{"w41", 23'h2AAAAA, 41,  1'b0, 1'b0};
        vecs[1] = '{"w42", 23'h155555, 42,  1'b0, 1'b1};
        vecs[2] = '{"w7",  23'h7FFFFF, 7,   1'b1, 1'b0};
        vecs[3] = '{"w8",  23'h0F0F0F, 8,   1'b0, 1'b0};
        vecs[4] = '{"w99", 23'h000001, 99,  1'b0, 1'b1};
        vecs[5] = '{"w100",23'h123456, 100, 1'b1, 1'b0};

        // Power-on reset
        rst     = 1'b1;
        bus.din = 1'b0;
        tick(2);
        check("rst_pixel_data",  32'(bus.pixel_data),  32'h0);
        check("rst_pixel_valid", 32'(bus.pixel_valid), 32'h0);
        check("rst_latch",       32'(bus.latch),       32'h0);
        check("rst_dout",        32'(bus.dout),        32'h0);
        check("rst_bit_error",   32'(bus.bit_error),   32'h0);
        rst = 1'b0;

        // First frame after the initial low period
        tick(GAP);
        snap();
        send_word(24'hA5C31F, 125, 24);
        check("po_valid_cnt", 32'(n_valid - v0), 32'd1);
        check("po_pixel",     32'(bus.pixel_data), 32'hA5C31F);
        check("po_err_cnt",   32'(n_err - e0), 32'd0);
        check("po_dout_hi",   32'(n_dout_hi - h0), 32'd0);
        tick(GAP);
        check("po_latch_cnt", 32'(n_latch - l0), 32'd1);

        // Threshold table: 23 filler bits, then the bit under test as bit 24
        for (int i = 0; i < 6; i++) begin
            snap();
            for (int j = 0; j < 23; j++)
                send_bit(vecs[i].pfx[22 - j] ? 60 : 24, 80);
            send_bit(vecs[i].w, 125);
            tick(GAP);
            check({vecs[i].name, "_err"},   32'(n_err - e0),   32'(vecs[i].exp_err));
            check({vecs[i].name, "_valid"}, 32'(n_valid - v0), 32'(!vecs[i].exp_err));
            check({vecs[i].name, "_latch"}, 32'(n_latch - l0), 32'(!vecs[i].exp_err));
            if (!vecs[i].exp_err)
                check({vecs[i].name, "_data"}, 32'(bus.pixel_data),
                      32'({vecs[i].pfx, vecs[i].exp_bit}));
        end

        // Chain: second pixel forwarded on dout
        snap();
        rb = dout_rise.size();
        wb = dout_width.size();
        db = din_rise.size();
        send_word(24'h123456, 125, 24);
        send_word(24'hFFFFFF, 125, 24);
        tick(2600);
        check("chain_valid_cnt", 32'(n_valid - v0), 32'd1);
        check("chain_pixel",     32'(bus.pixel_data), 32'h123456);
        check("chain_pulses",    32'(dout_rise.size() - rb), 32'd24);
        check("chain_widths_n",  32'(dout_width.size() - wb), 32'd24);
        nbad_w = 0;
        nbad_d = 0;
        for (int i = 0; i < 24; i++) begin
            if (wb + i < dout_width.size() && dout_width[wb + i] != 60) nbad_w++;
            if (rb + i < dout_rise.size() && dout_rise[rb + i] - din_rise[db + 24 + i] != 3) nbad_d++;
        end
        check("chain_width_errs", 32'(nbad_w), 32'd0);
        check("chain_delay_errs", 32'(nbad_d), 32'd0);
        check("chain_latch_cnt",  32'(n_latch - l0), 32'd1);
        check_range("chain_latch_delay", latch_cyc - last_fall, 2498, 2506);
        check("chain_dout_end",   32'(bus.dout), 32'h0);

        // Error recovery: glitch on bit 10
        snap();
        send_word(24'hFFFFFF, 125, 9);
        send_bit(4, 125);
        send_word(24'h000000, 80, 5);
        tick(GAP);
        check("err_err_cnt",   32'(n_err - e0),   32'd1);
        check("err_valid_cnt", 32'(n_valid - v0), 32'd0);
        check("err_latch_cnt", 32'(n_latch - l0), 32'd0);
        snap();
        send_word(24'h5A3C96, 80, 24);
        tick(GAP);
        check("rec_valid_cnt", 32'(n_valid - v0), 32'd1);
        check("rec_pixel",     32'(bus.pixel_data), 32'h5A3C96);
        check("rec_latch_cnt", 32'(n_latch - l0), 32'd1);

        // Partial frame discarded by a gap
        snap();
        send_word(24'hABCDEF, 125, 12);
        tick(GAP);
        check("part_valid_cnt", 32'(n_valid - v0), 32'd0);
        check("part_latch_cnt", 32'(n_latch - l0), 32'd0);
        send_word(24'h0F0F0F, 80, 24);
        tick(GAP);
        check("part2_valid_cnt", 32'(n_valid - v0), 32'd1);
        check("part2_pixel",     32'(bus.pixel_data), 32'h0F0F0F);
        check("part2_latch_cnt", 32'(n_latch - l0), 32'd1);

        // Reset in the middle of bit 15
        snap();
        send_word(24'hC0FFEE, 125, 14);
        bus.din = 1'b1;
        tick(30);
        rst = 1'b1;
        tick(1);
        check("mid_rst_pixel_data",  32'(bus.pixel_data),  32'h0);
        check("mid_rst_pixel_valid", 32'(bus.pixel_valid), 32'h0);
        check("mid_rst_dout",        32'(bus.dout),        32'h0);
        rst = 1'b0;
        tick(30);
        bus.din = 1'b0;
        tick(65);
        send_word(24'h777777, 80, 10);
        check("mid_rst_junk_valid", 32'(n_valid - v0), 32'd0);
        tick(GAP);
        send_word(24'h3CA5E1, 80, 24);
        tick(GAP);
        check("mid_rst_valid_cnt", 32'(n_valid - v0), 32'd1);
        check("mid_rst_pixel",     32'(bus.pixel_data), 32'h3CA5E1);
        check("mid_rst_latch_cnt", 32'(n_latch - l0), 32'd1);
        check("mid_rst_err_cnt",   32'(n_err - e0), 32'd0);

        check("valid_latch_overlap", 32'(n_both), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2811_rx.md
Name: ws2811_rx

Overview:
- Receive-side counterpart of the WS2811 bit encoder: decodes a 50 MHz-sampled WS2811 one-wire stream back into 24-bit pixel words.
- Behaves like the first LED in a chain. It captures the first 24 bits of each frame, then forwards all later bits on dout, and reports the latch gap.
- Used as a loopback checker for the LED driver and as a front end for chained-controller boards.

Parameters:
- T_MIN_HIGH, 8: high pulses shorter than this many clk cycles are glitches (error).
- T_THRESH, 42: high width >= T_THRESH decodes as 1; below it decodes as 0. Nominal widths are 24 and 60 in a 125-cycle bit.
- T_MAX_HIGH, 100: high width reaching this count is an error.
- RESET_CYCLES, 2500: consecutive low cycles (50 us) that constitute the latch/reset gap.

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  synchronous, active-high reset
- din  in  1  asynchronous WS2811 line input
- pixel_data  out  24  last captured pixel, first received bit in bit 23 (raw GRB order)
- pixel_valid  out  1  one-cycle pulse when pixel_data updates
- latch  out  1  one-cycle pulse at the end of a latch gap in which a pixel was captured
- dout  out  1  forwarded stream for the next device
- bit_error  out  1  one-cycle pulse on a malformed bit

Behaviour:
- One clock; reset is synchronous and active-high (rst sampled on rising clk).
- Reset values:
  - pixel_data=0, pixel_valid=0, latch=0, dout=0, bit_error=0.
  - State SYNC; counters and bit count at 0; fwd flag=0; captured flag=0.
- din passes through a 2-flop synchronizer giving ds. All timing below is in terms of ds.
- high_cnt and low_cnt are 8-bit and 12-bit counters and saturate; they never wrap.

State machine:
- SYNC:
  - Counts consecutive ds=0 cycles in low_cnt; ds=1 clears low_cnt.
  - When low_cnt reaches RESET_CYCLES: go to LOW, clear bit count. No latch pulse is issued.
- LOW:
  - ds=0 increments low_cnt.
  - When low_cnt reaches RESET_CYCLES (gap):
    - latch=1 for one cycle if the captured flag is set, then clear the captured flag.
    - Clear fwd and the bit count; any partial bits are discarded silently.
    - Remain in LOW, with low_cnt held saturated.
  - ds=1: high_cnt=1, low_cnt=0, go to HIGH.
- HIGH:
  - ds=1 increments high_cnt. If high_cnt reaches T_MAX_HIGH: bit_error pulse, go to SYNC.
  - ds=0 (falling edge), classify using high_cnt:
    - high_cnt < T_MIN_HIGH: bit_error pulse, go to SYNC.
    - Otherwise bit = (high_cnt >= T_THRESH), and go to LOW.
  - Handling of a classified bit:
    - fwd=0: shift the bit into the 24-bit shift register, MSB first.
    - On the 24th bit: pixel_data <= shift result and pixel_valid=1 on the next cycle. Set fwd=1 and the captured flag; clear the bit count.
    - fwd=1: the bit is not captured (forwarded only).
- Error entry into SYNC:
  - Discards partial bits and clears fwd.
  - Keeps the captured flag, so a later valid gap still reports latch.

dout:
- dout = ds registered (3 cycles after din) while fwd=1; otherwise 0.
- The 24th captured bit's own waveform is not forwarded.
- dout drops to 0 on the cycle after fwd clears.

Simultaneous and corner cases:
- A gap, then a rising edge: the gap is processed first and the edge on the following cycle starts bit 1 of a new frame.
- rst mid-bit aborts immediately. The first post-reset frame is accepted only after a full RESET_CYCLES low period.
- pixel_valid and latch never assert in the same cycle.
- Bit period is not checked; only high width and the gap define validity.

Test Plan:
- Power-on: rst 2 cycles, din low 2500+ cycles, then 24 bits of 0xA5C31F (widths 60/24, 125-cycle period) -> pixel_valid once, pixel_data=0xA5C31F, no bit_error, dout=0 throughout.
- Chain: 48 bits (0x123456 then 0xFFFFFF) then 2600 low cycles:
  - pixel_data=0x123456.
  - dout reproduces the second 24 pulses with 3-cycle delay and equal widths.
  - latch pulses once, about 2500 cycles after the last falling edge.
  - dout then 0.
- Threshold: high widths 41 and 42 -> decoded 0 and 1 respectively. Widths 7 -> bit_error; 8 -> valid 0; 99 -> valid 1; 100 -> bit_error.
- Error recovery: glitch at bit 10 -> bit_error, no pixel_valid. After 2500 low cycles and a fresh 24-bit frame -> correct pixel. The gap following the error-aborted frame yields no latch unless a pixel had been captured.
- Partial frame: 12 bits then 2500 low -> no pixel_valid, no latch. Next 24 bits decode cleanly.
- Reset mid-frame: rst asserted during bit 15 -> all outputs 0 next cycle. Bits sent before 2500 low cycles are ignored.
